alu_secuencial: RTL and testbench

//  Parametrised, clocked successor of the 8-bit combinational ALU. Each operation
//  (opcode + two operands) is accepted through a valid/ready handshake and returns a

---
 rtl/alu_pkg.sv | 20 ++
 rtl/alu_iterativa.sv | 70 +++++++
 rtl/alu_secuencial.sv | 140 ++++++++++++++
 tb/tb_alu_secuencial.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared opcodes and FSM state encoding for the sequential ALU.
// Imported by alu_secuencial and its testbench.
package alu_pkg;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_SHL = 3'b101;
    localparam logic [2:0] OP_MUL = 3'b110;
    localparam logic [2:0] OP_111 = 3'b111;

    typedef enum logic [1:0] {
        OCIOSO    = 2'b00,
        ITERA     = 2'b01,
        RESULTADO = 2'b10
    } estado_t;

endpackage

// File: rtl/alu_iterativa.sv
// Shared iterative datapath: shift-add multiply and restoring divide.
// One bit per cycle for ANCHO cycles; done flags the last iteration.
module alu_iterativa #(
    parameter int ANCHO = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               op_div,
    input  logic [ANCHO-1:0]   a,
    input  logic [ANCHO-1:0]   b,
    output logic               done,
    output logic [2*ANCHO-1:0] resultado
);

    localparam int CW = $clog2(ANCHO);
    localparam logic [CW-1:0] ULT = CW'(ANCHO - 1);

    logic [2*ANCHO-1:0] acc;
    logic [2*ANCHO-1:0] sig;
    logic [ANCHO-1:0]   b_r;
    logic               div_r;
    logic               busy;
    logic [CW-1:0]      cnt;
    logic [ANCHO:0]     suma;
    logic [ANCHO:0]     parcial;
    logic [ANCHO:0]     dif;

    // MUL: acc = {partial product, remaining multiplier bits}
    // DIV: acc = {partial remainder, remaining dividend / quotient bits}
    assign suma    = {1'b0, acc[2*ANCHO-1:ANCHO]}
                   + {1'b0, (acc[0] ? b_r : {ANCHO{1'b0}})};
    assign parcial = {acc[2*ANCHO-1:ANCHO], acc[ANCHO-1]};
    assign dif     = parcial - {1'b0, b_r};

    always_comb begin
        sig = {suma, acc[ANCHO-1:1]};
        if (div_r) begin
            if (parcial >= {1'b0, b_r})
                sig = {dif[ANCHO-1:0], acc[ANCHO-2:0], 1'b1};
            else
                sig = {parcial[ANCHO-1:0], acc[ANCHO-2:0], 1'b0};
        end
    end

    assign done      = busy & (cnt == ULT);
    assign resultado = sig;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc   <= '0;
            b_r   <= '0;
            div_r <= 1'b0;
            busy  <= 1'b0;
            cnt   <= '0;
        end else if (start) begin
            acc   <= {{ANCHO{1'b0}}, a};
            b_r   <= b;
            div_r <= op_div;
            busy  <= 1'b1;
            cnt   <= '0;
        end else if (busy) begin
            acc <= sig;
            cnt <= cnt + CW'(1);
            if (cnt == ULT)
                busy <= 1'b0;
        end
    end

endmodule

// File: rtl/alu_secuencial.sv
// Clocked ALU with valid/ready in and out; MUL (and DIV) iterate ANCHO cycles.
// Define ALU_DIV_EN to make opcode 111 a restoring DIV; otherwise it is SHR.
module alu_secuencial
    import alu_pkg::*;
#(
    parameter int ANCHO = 8
) (
    input  logic               Reloj,
    input  logic               Reinicio_n,
    input  logic               entrada_valida,
    output logic               entrada_lista,
    input  logic [2:0]         Codigo_OP,
    input  logic [ANCHO-1:0]   Dato0,
    input  logic [ANCHO-1:0]   Dato1,
    output logic               salida_valida,
    input  logic               salida_lista,
    output logic [2*ANCHO-1:0] Resultado,
    output logic               banderaA,
    output logic               banderaB
);

    localparam int ANCHO_DESP = $clog2(ANCHO);

    estado_t               estado;
    logic                  listo;
    logic                  acepta;
    logic                  toma;
    logic                  es_iter;
    logic                  iter_div;
    logic                  op_div_r;
    logic                  div0_r;
    logic                  iter_fin;
    logic [2*ANCHO-1:0]    iter_res;
    logic [ANCHO-1:0]      res_simple;
    logic                  flag_simple;
    logic [ANCHO:0]        suma;
    logic [ANCHO:0]        resta;
    logic [ANCHO_DESP-1:0] desp;

    // listo keeps the input side closed until the first edge after reset
    assign entrada_lista = listo & ((estado == OCIOSO) |
                           ((estado == RESULTADO) & salida_lista));
    assign acepta = entrada_valida & entrada_lista;
    assign toma   = salida_valida & salida_lista;

    assign suma  = {1'b0, Dato0} + {1'b0, Dato1};
    assign resta = {1'b0, Dato0} - {1'b0, Dato1};
    assign desp  = Dato1[ANCHO_DESP-1:0];

`ifdef ALU_DIV_EN
    assign iter_div = (Codigo_OP == OP_111);
`else
    assign iter_div = 1'b0;
`endif
    assign es_iter = (Codigo_OP == OP_MUL) | iter_div;

    always_comb begin
        res_simple  = '0;
        flag_simple = 1'b0;
        case (Codigo_OP)
            OP_ADD: begin
                res_simple  = suma[ANCHO-1:0];
                flag_simple = suma[ANCHO];
            end
            OP_SUB: begin
                res_simple  = resta[ANCHO-1:0];
                flag_simple = resta[ANCHO];
            end
            OP_AND: res_simple = Dato0 & Dato1;
            OP_OR:  res_simple = Dato0 | Dato1;
            OP_XOR: res_simple = Dato0 ^ Dato1;
            OP_SHL: res_simple = Dato0 << desp;
`ifndef ALU_DIV_EN
            OP_111: res_simple = Dato0 >> desp;
`endif
            default: ;
        endcase
    end

    alu_iterativa #(
        .ANCHO(ANCHO)
    ) u_iter (
        .clk      (Reloj),
        .rst_n    (Reinicio_n),
        .start    (acepta & es_iter),
        .op_div   (iter_div),
        .a        (Dato0),
        .b        (Dato1),
        .done     (iter_fin),
        .resultado(iter_res)
    );

    always_ff @(posedge Reloj or negedge Reinicio_n) begin
        if (!Reinicio_n) begin
            estado        <= OCIOSO;
            listo         <= 1'b0;
            salida_valida <= 1'b0;
            Resultado     <= '0;
            banderaA      <= 1'b0;
            banderaB      <= 1'b0;
            op_div_r      <= 1'b0;
            div0_r        <= 1'b0;
        end else begin
            listo <= 1'b1;
            case (estado)
                OCIOSO, RESULTADO: begin
                    if (toma) begin
                        salida_valida <= 1'b0;
                        estado        <= OCIOSO;
                    end
                    if (acepta) begin
                        if (es_iter) begin
                            op_div_r      <= iter_div;
                            div0_r        <= (Dato1 == '0);
                            salida_valida <= 1'b0;
                            estado        <= ITERA;
                        end else begin
                            Resultado     <= {{ANCHO{1'b0}}, res_simple};
                            banderaA      <= flag_simple;
                            banderaB      <= (res_simple == '0);
                            salida_valida <= 1'b1;
                            estado        <= RESULTADO;
                        end
                    end
                end
                ITERA: begin
                    if (iter_fin) begin
                        Resultado     <= iter_res;
                        banderaA      <= op_div_r & div0_r;
                        banderaB      <= (iter_res == '0);
                        salida_valida <= 1'b1;
                        estado        <= RESULTADO;
                    end
                end
                default: estado <= OCIOSO;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_secuencial.sv
// Directed and randomised checks of alu_secuencial at ANCHO=8.
// Honours ALU_DIV_EN the same way as the design.
module tb_alu_secuencial;
    import alu_pkg::*;

    localparam int NUM = 200;

    logic        Reloj;
    logic        Reinicio_n;
    logic        entrada_valida;
    logic        entrada_lista;
    logic [2:0]  Codigo_OP;
    logic [7:0]  Dato0;
    logic [7:0]  Dato1;
    logic        salida_valida;
    logic        salida_lista;
    logic [15:0] Resultado;
    logic        banderaA;
    logic        banderaB;

    int checks = 0;
    int errors = 0;

    alu_secuencial #(.ANCHO(8)) dut (
        .Reloj         (Reloj),
        .Reinicio_n    (Reinicio_n),
        .entrada_valida(entrada_valida),
        .entrada_lista (entrada_lista),
        .Codigo_OP     (Codigo_OP),
        .Dato0         (Dato0),
        .Dato1         (Dato1),
        .salida_valida (salida_valida),
        .salida_lista  (salida_lista),
        .Resultado     (Resultado),
        .banderaA      (banderaA),
        .banderaB      (banderaB)
    );

    initial Reloj = 1'b0;
    always #5 Reloj = ~Reloj;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
        end
    endtask

    // {banderaA, banderaB, Resultado}
    function automatic logic [17:0] modelo(input logic [2:0] op,
                                           input logic [7:0] a,
                                           input logic [7:0] b);
        logic [15:0] r;
        logic        fa;
        int          s;
        r  = '0;
        fa = 1'b0;
        case (op)
            3'd0: begin
                s  = int'(a) + int'(b);
                r  = {8'h00, 8'(s)};
                fa = (s > 255);
            end
            3'd1: begin
                r  = {8'h00, 8'(a - b)};
                fa = (a < b);
            end
            3'd2: r = {8'h00, a & b};
            3'd3: r = {8'h00, a | b};
            3'd4: r = {8'h00, a ^ b};
            3'd5: r = {8'h00, 8'(a << b[2:0])};
            3'd6: r = 16'(a) * 16'(b);
            default: begin
`ifdef ALU_DIV_EN
                if (b == 8'h00) begin
                    r  = {a, 8'hFF};
                    fa = 1'b1;
                end else begin
                    r = {8'(a % b), 8'(a / b)};
                end
`else
                r = {8'h00, a >> b[2:0]};
`endif
            end
        endcase
        return {fa, (r == 16'h0000), r};
    endfunction

    task automatic enviar(input logic [2:0] op, input logic [7:0] a,
                          input logic [7:0] b);
        int n;
        Codigo_OP      = op;
        Dato0          = a;
        Dato1          = b;
        entrada_valida = 1'b1;
        n = 0;
        while (!entrada_lista && n < 50) begin
            @(posedge Reloj); #1;
            n++;
        end
        chk("accept", {31'b0, entrada_lista}, 32'd1);
        @(posedge Reloj); #1;
        entrada_valida = 1'b0;
        Dato0          = 8'($urandom);
        Dato1          = 8'($urandom);
    endtask

    task automatic ejecutar(input string tag, input logic [2:0] op,
                            input logic [7:0] a, input logic [7:0] b,
                            input logic [15:0] e_res, input logic e_a,
                            input logic e_b, input int e_lat);
        int lat;
        enviar(op, a, b);
        if (e_lat > 1)
            chk({tag, "_busy_ready"}, {31'b0, entrada_lista}, 32'd0);
        lat = 0;
        while (!salida_valida && lat < 40) begin
            @(posedge Reloj); #1;
            lat++;
        end
        chk({tag, "_lat"}, lat + 1, e_lat);
        chk({tag, "_res"}, {16'b0, Resultado}, {16'b0, e_res});
        chk({tag, "_A"}, {31'b0, banderaA}, {31'b0, e_a});
        chk({tag, "_B"}, {31'b0, banderaB}, {31'b0, e_b});
    endtask

    initial begin
        int          vcnt;
        int          sent;
        int          got;
        logic        pend;
        logic [17:0] q[$];
        logic [17:0] e;
        logic [15:0] snap;

        Reinicio_n     = 1'b0;
        entrada_valida = 1'b0;
        Codigo_OP      = OP_ADD;
        Dato0          = '0;
        Dato1          = '0;
        salida_lista   = 1'b1;
        repeat (3) @(posedge Reloj);
        #1;
        chk("rst_res", {16'b0, Resultado}, 32'd0);
        chk("rst_valid", {31'b0, salida_valida}, 32'd0);
        chk("rst_ready", {31'b0, entrada_lista}, 32'd0);
        chk("rst_flags", {30'b0, banderaA, banderaB}, 32'd0);
        @(negedge Reloj);
        Reinicio_n = 1'b1;
        @(posedge Reloj); #1;
        chk("rel_ready", {31'b0, entrada_lista}, 32'd1);

        ejecutar("add", OP_ADD, 8'd16, 8'd55, 16'h0047, 1'b0, 1'b0, 1);
        ejecutar("sub", OP_SUB, 8'd16, 8'd55, 16'h00D9, 1'b1, 1'b0, 1);
        ejecutar("xor", OP_XOR, 8'h37, 8'h37, 16'h0000, 1'b0, 1'b1, 1);
        ejecutar("and", OP_AND, 8'hF0, 8'h3C, 16'h0030, 1'b0, 1'b0, 1);
        ejecutar("or",  OP_OR,  8'hF0, 8'h0C, 16'h00FC, 1'b0, 1'b0, 1);
        ejecutar("shl", OP_SHL, 8'h81, 8'h0B, 16'h0008, 1'b0, 1'b0, 1);
        ejecutar("mul", OP_MUL, 8'd16, 8'd55, 16'h0370, 1'b0, 1'b0, 9);
        ejecutar("mulmax", OP_MUL, 8'hFF, 8'hFF, 16'hFE01, 1'b0, 1'b0, 9);
        ejecutar("addc", OP_ADD, 8'd255, 8'd1, 16'h0000, 1'b1, 1'b1, 1);
`ifdef ALU_DIV_EN
        ejecutar("div_a", OP_111, 8'd16, 8'd55, 16'h1000, 1'b0, 1'b0, 9);
        ejecutar("div_b", OP_111, 8'd55, 8'd16, 16'h0703, 1'b0, 1'b0, 9);
        ejecutar("div_0", OP_111, 8'd16, 8'd0, 16'h10FF, 1'b1, 1'b0, 9);
`else
        ejecutar("shr", OP_111, 8'h80, 8'd3, 16'h0010, 1'b0, 1'b0, 1);
`endif

        // reset in the middle of a multiply
        enviar(OP_MUL, 8'd9, 8'd7);
        repeat (3) @(posedge Reloj);
        #1;
        Reinicio_n = 1'b0;
        #1;
        chk("mid_rst_res", {16'b0, Resultado}, 32'd0);
        chk("mid_rst_valid", {31'b0, salida_valida}, 32'd0);
        chk("mid_rst_ready", {31'b0, entrada_lista}, 32'd0);
        @(negedge Reloj);
        Reinicio_n = 1'b1;
        @(posedge Reloj); #1;
        chk("mid_rel_ready", {31'b0, entrada_lista}, 32'd1);
        vcnt = 0;
        repeat (12) begin
            if (salida_valida) vcnt++;
            @(posedge Reloj); #1;
        end
        chk("mid_rst_noresult", vcnt, 0);

        // backpressure
        salida_lista = 1'b0;
        ejecutar("bp", OP_ADD, 8'h30, 8'h05, 16'h0035, 1'b0, 1'b0, 1);
        snap = Resultado;
        repeat (5) begin
            Dato0 = 8'($urandom);
            Codigo_OP = 3'($urandom_range(0, 7));
            @(posedge Reloj); #1;
            chk("bp_hold", {16'b0, Resultado}, {16'b0, snap});
            chk("bp_valid", {31'b0, salida_valida}, 32'd1);
            chk("bp_ready", {31'b0, entrada_lista}, 32'd0);
        end
        salida_lista = 1'b1;
        @(posedge Reloj); #1;
        chk("bp_drain", {31'b0, salida_valida}, 32'd0);

        // back-to-back adds, one result per cycle
        Codigo_OP      = OP_ADD;
        entrada_valida = 1'b1;
        for (int i = 0; i < 4; i++) begin
            Dato0 = 8'(20 + i);
            Dato1 = 8'(i);
            chk("b2b_ready", {31'b0, entrada_lista}, 32'd1);
            @(posedge Reloj); #1;
            chk("b2b_valid", {31'b0, salida_valida}, 32'd1);
            chk("b2b_res", {16'b0, Resultado}, 32'(20 + 2 * i));
        end
        entrada_valida = 1'b0;
        @(posedge Reloj); #1;

        // random ops with stalls on both sides
        sent = 0;
        got  = 0;
        pend = 1'b0;
        for (int c = 0; c < 8000 && got < NUM; c++) begin
            @(posedge Reloj); #1;
            salida_lista = ($urandom_range(0, 3) != 0);
            if (!pend) begin
                if (sent < NUM && $urandom_range(0, 2) != 0) begin
                    Codigo_OP = 3'($urandom_range(0, 7));
                    Dato0     = 8'($urandom);
                    Dato1     = ($urandom_range(0, 7) == 0) ? 8'h00
                                                            : 8'($urandom);
                    entrada_valida = 1'b1;
                    pend = 1'b1;
                end else begin
                    entrada_valida = 1'b0;
                    Dato0 = 8'($urandom);
                end
            end
            #1;
            if (salida_valida && salida_lista) begin
                if (q.size() == 0) begin
                    chk("rnd_spurious", {31'b0, salida_valida}, 32'd0);
                end else begin
                    e = q.pop_front();
                    chk("rnd", {14'b0, banderaA, banderaB, Resultado},
                        {14'b0, e});
                end
                got++;
            end
            if (entrada_valida && entrada_lista) begin
                q.push_back(modelo(Codigo_OP, Dato0, Dato1));
                sent++;
                pend = 1'b0;
            end
        end
        entrada_valida = 1'b0;
        chk("rnd_count", got, NUM);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
